// File: rtl/mem_arbiter.sv
// Arbitrates one main-memory port between I-cache and D-cache miss traffic.
// Default build is fixed priority (D over I); define ARB_RR_EN for round-robin on ties.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_req,
    input  logic [ADDR_W-1:0]     ic_addr,
    output logic [DATA_W-1:0]     ic_rdata,
    output logic                  ic_ack,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_W-1:0]     dc_addr,
    input  logic [DATA_W-1:0]     dc_wdata,
    input  logic [DATA_W/8-1:0]   dc_wstrb,
    output logic [DATA_W-1:0]     dc_rdata,
    output logic                  dc_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  waiting
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;
    typedef enum logic {LG_I = 1'b0, LG_D = 1'b1} grant_e;

    state_e              state_q, state_d;
    grant_e              last_grant_q, last_grant_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
    logic                ic_ack_q, ic_ack_d;
    logic                dc_ack_q, dc_ack_d;

    logic ic_elig, dc_elig, pick_d;

    // A requester still sees its own ack this cycle, so it is masked to avoid a re-grant.
    assign ic_elig = ic_req && !ic_ack_q;
    assign dc_elig = dc_req && !dc_ack_q;

`ifdef ARB_RR_EN
    assign pick_d = dc_elig && (!ic_elig || last_grant_q == LG_I);
`else
    assign pick_d = dc_elig;
`endif

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        ic_rdata_d   = ic_rdata_q;
        dc_rdata_d   = dc_rdata_q;
        ic_ack_d     = 1'b0;
        dc_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d     = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dc_we;
                    mem_addr_d  = dc_addr;
                    mem_wdata_d = dc_wdata;
                    mem_wstrb_d = dc_wstrb;
                end else if (ic_elig) begin
                    state_d     = GNT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ic_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
            end
            GNT_I: begin
                if (mem_ready) begin
                    ic_rdata_d   = mem_rdata;
                    ic_ack_d     = 1'b1;
                    mem_req_d    = 1'b0;
                    last_grant_d = LG_I;
                    state_d      = IDLE;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        dc_rdata_d = mem_rdata;
                    end
                    dc_ack_d     = 1'b1;
                    mem_req_d    = 1'b0;
                    last_grant_d = LG_D;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values in parallel.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LG_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            ic_rdata_q   <= '0;
            dc_rdata_q   <= '0;
            ic_ack_q     <= 1'b0;
            dc_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            ic_rdata_q   <= ic_rdata_d;
            dc_rdata_q   <= dc_rdata_d;
            ic_ack_q     <= ic_ack_d;
            dc_ack_q     <= dc_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign ic_ack    = ic_ack_q;
    assign dc_ack    = dc_ack_q;
    assign waiting   = (ic_req && !ic_ack_q) || (dc_req && !dc_ack_q);

endmodule
